// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// funct3 op codes and FSM state encoding.
package mul_div_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-facing bundle of the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  // start is held high by EX until done pulses; stall = start & ~done & ~flush.
  // The op is taken on the first IDLE cycle with start=1 and flush=0, and
  // result is valid only in the single cycle where done=1.
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output result, done, busy, stall
  );

endinterface

// File: rtl/mul_div_unit_div_iter.sv
// Iterative restoring divider: magnitudes in, one quotient bit per step,
// signed fix-up applied to the final step's values.
module div_iter
  import mul_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              is_signed,
  input  logic              want_rem,
  output logic              last,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [5:0]        cnt_q;
  logic              q_neg_q, r_neg_q, want_rem_q;

  logic [DATA_W:0]   shifted;
  logic              ge;
  logic [DATA_W-1:0] rem_d, quo_d;

  // quo_q starts as the dividend magnitude; its MSB shifts into the remainder each step.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    ge      = shifted[DATA_W] | (shifted[DATA_W-1:0] >= dvs_q);
    rem_d   = ge ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
    quo_d   = {quo_q[DATA_W-2:0], ge};
    last    = step & (cnt_q == 6'd31);
    result  = want_rem_q ? neg_if(rem_d, r_neg_q) : neg_if(quo_d, q_neg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      want_rem_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      rem_q      <= '0;
      quo_q      <= neg_if(dividend, is_signed & dividend[DATA_W-1]);
      dvs_q      <= neg_if(divisor, is_signed & divisor[DATA_W-1]);
      q_neg_q    <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      r_neg_q    <= is_signed & dividend[DATA_W-1];
      want_rem_q <= want_rem;
      cnt_q      <= '0;
    end else if (step) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execute-stage unit: two-cycle multiplier, 32-step iterative divider,
// and the IDLE/MUL/DIV/DONE control FSM that stalls the front of the pipe.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus,
  output state_t         dbg_state
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [2:0]      f3_q;
  logic            a_sx_q, b_sx_q;

  logic            accept, is_div_op, div_zero, div_ovf, special, done;
  logic [XLEN-1:0] special_val, mul_val, div_result;
  logic [XLEN:0]   a_ext, b_ext;
  logic [2*XLEN-1:0] a_wide, b_wide, product;
  logic            div_last;

  // Zero divisor and signed overflow resolve without iterating.
  always_comb begin
    is_div_op = bus.funct3[2];
    div_zero  = (bus.rs2_data == '0);
    div_ovf   = ~bus.funct3[0] & (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
              & (bus.rs2_data == '1);
    special   = is_div_op & (div_zero | div_ovf);
    if (div_zero) special_val = bus.funct3[1] ? bus.rs1_data : '1;
    else          special_val = bus.funct3[1] ? '0 : bus.rs1_data;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          accept = 1'b1;
          if (!is_div_op)   state_d = ST_MUL;
          else if (special) state_d = ST_DONE;
          else              state_d = ST_DIV;
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (div_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      f3_q   <= '0;
      a_sx_q <= 1'b0;
      b_sx_q <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.rs1_data;
      b_q    <= bus.rs2_data;
      f3_q   <= bus.funct3;
      a_sx_q <= (bus.funct3 == F3_MULH) | (bus.funct3 == F3_MULHSU);
      b_sx_q <= (bus.funct3 == F3_MULH);
    end
  end

  // 33-bit extended operands; sign-extending to 64 bits keeps the low 64 product bits exact.
  always_comb begin
    a_ext   = {a_sx_q & a_q[XLEN-1], a_q};
    b_ext   = {b_sx_q & b_q[XLEN-1], b_q};
    a_wide  = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
    b_wide  = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    product = a_wide * b_wide;
    mul_val = (f3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  div_iter u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.flush),
    .load      (accept & is_div_op & ~special),
    .step      (state_q == ST_DIV),
    .dividend  (bus.rs1_data),
    .divisor   (bus.rs2_data),
    .is_signed (~bus.funct3[0]),
    .want_rem  (bus.funct3[1]),
    .last      (div_last),
    .result    (div_result)
  );

  // result only changes on the edge that enters DONE, so it holds between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          result_q <= '0;
    else if (accept && special)                          result_q <= special_val;
    else if (state_q == ST_MUL && !bus.flush)            result_q <= mul_val;
    else if (state_q == ST_DIV && div_last && !bus.flush) result_q <= div_result;
  end

  assign done       = (state_q == ST_DONE) & ~bus.flush;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.stall  = bus.start & ~done & ~bus.flush;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table, randomized ops against a reference
// model, and flush/reset sequences; results checked through an expected queue.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  mul_div_unit_if #(.XLEN(DATA_W)) bus ();

  mul_div_unit #(.XLEN(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers, independent of the RTL datapath.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'h0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Scoreboard: every done pops one expected result; a done with nothing pending is an error.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no pending op (result 0x%08h)", bus.result);
      end else begin
        check("result", bus.result, exp_q.pop_front());
      end
    end
  end

  // Called just after a negedge with the unit IDLE; returns just after the negedge following DONE.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    int  k;
    bit  seen;
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    exp_q.push_back(exp);
    #1;
    check1({tag, "_stall_T"}, bus.stall, 1'b1);
    check1({tag, "_busy_T"}, bus.busy, 1'b0);
    seen = 1'b0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
      end
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      check1({tag, "_stall_wait"}, bus.stall, 1'b1);
      check1({tag, "_busy_wait"}, bus.busy, 1'b1);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done in 60 cycles expected done at T+%0d", tag, lat);
      void'(exp_q.pop_back());
    end else begin
      check({tag, "_latency"}, 32'(k), 32'(lat));
      check1({tag, "_stall_done"}, bus.stall, 1'b0);
      check1({tag, "_busy_done"}, bus.busy, 1'b1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check1({tag, "_busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[2]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2};
    vecs[3]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
    vecs[4]  = '{F3_MULH,   32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 2};
    vecs[5]  = '{F3_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 2};
    vecs[6]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[7]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[8]  = '{F3_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{F3_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{F3_DIV,    32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[13] = '{F3_REM,    32'hFFFF_FFFD, 32'h0000_0000, 32'hFFFF_FFFD, 1};
    vecs[14] = '{F3_DIVU,   32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555, 33};
    vecs[15] = '{F3_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
    vecs[16] = '{F3_DIV,    32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
    vecs[17] = '{F3_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 33};
    vecs[18] = '{F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[19] = '{F3_REM,    32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 33};

    // Clock/reset
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", bus.result, 32'h0);
    check1("reset_done", bus.done, 1'b0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_stall", bus.stall, 1'b0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back
    for (int i = 0; i < 20; i++)
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Randomized ops checked against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = 32'h0;
      if (i % 5 == 1) b = $urandom_range(1, 9);
      do_op(f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b), $sformatf("rand%0d", i));
    end

    // Flush of an in-flight DIV at T+10, then MUL accepted at T+11
    bus.start    = 1'b1;
    bus.funct3   = F3_DIV;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check1("flush_done", bus.done, 1'b0);
    check1("flush_stall", bus.stall, 1'b0);
    check1("flush_busy_T10", bus.busy, 1'b1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check1("flush_busy_T11", bus.busy, 1'b0);
    check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
    do_op(F3_MUL, 32'd6, 32'd7, 32'd42, 2, "mul_after_flush");

    // Reset asserted at T+5 of a DIV
    bus.start    = 1'b1;
    bus.funct3   = F3_DIVU;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd3;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", bus.result, 32'h0);
    check1("rst_mid_done", bus.done, 1'b0);
    check1("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      bit any_busy;
      any_busy = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.busy || bus.done) any_busy = 1'b1;
      end
      check1("rst_quiet_after_release", any_busy, 1'b0);
    end
    do_op(F3_REMU, 32'd1000, 32'd3, 32'd1, 33, "after_reset");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  EX holds an RV32M instruction; held high while stalled.
REQ-005 SHALL have port funct3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have ports rs1_data and rs2_data  input  32 each  forwarded EX operands, post-forwarding.
REQ-007 SHALL have port flush  input  1  kill the EX instruction (branch/trap).
REQ-008 SHALL have port result  output  32  operation result, valid when done=1.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  unit is in any state other than IDLE.
REQ-011 SHALL have port stall  output  1  combinational; equals start & ~done & ~flush; freezes IF/ID/EX.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL accept an operation only in IDLE with start=1 and flush=0 (cycle T), latching funct3, operands, and operand signs.
REQ-014 SHALL transition IDLE->MUL for funct3[2]=0; MUL->DONE after one cycle; done=1 at T+2.
REQ-015 MUL state SHALL form a 64-bit product of 33-bit extended operands: both signed (MULH), rs1 signed/rs2 unsigned (MULHSU), otherwise unsigned.
REQ-016 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-017 SHALL transition IDLE->DIV for funct3[2]=1 with divisor nonzero and no signed overflow; done=1 at T+33.
REQ-018 DIV SHALL use restoring division on magnitudes, one quotient bit per cycle for 32 cycles, tracked by a 6-bit counter.
REQ-019 Signed DIV/REM SHALL negate the quotient when operand signs differ; the remainder SHALL take the dividend's sign.
REQ-020 Divide-by-zero SHALL go IDLE->DONE: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1; done=1 at T+1.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL go IDLE->DONE: DIV returns 0x80000000, REM returns 0, done at T+1.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; start is ignored in DONE.
REQ-023 result SHALL be registered and hold its value until the next DONE.
REQ-024 flush SHALL take priority over start and completion: any state -> IDLE next cycle; done is suppressed in that cycle.
REQ-025 Operand changes after acceptance SHALL have no effect on the in-flight operation.
REQ-026 start high in IDLE on the cycle after DONE SHALL be accepted as a new operation (back-to-back).

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, result=0, done=0, busy=0, counter=0, and all latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow reset release.

Structure
REQ-029 funct3 op codes and FSM state encodings SHALL reside in the shared include alongside the existing instruction-spec defines.
REQ-030 The iterative divider datapath (remainder/quotient registers, counter, sign fix-up) SHALL be a sub-module named div_iter; multiply and FSM stay in mul_div_unit.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done at T+2, stall high in T and T+1 only.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at T+33; REM on the same operands -> 0xFFFFFFFF; busy high T+1..T+33.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF at T+1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 DIV flushed at T+10 -> no done, busy low at T+11; MUL started at T+11 -> done at T+13.
REQ-036 rst_n low at T+5 of a DIV -> outputs 0 immediately; no done after release; the next operation completes correctly.
